display_scan_controller: RTL and testbench

//   Drives time-multiplexed scanning of the 4-digit seven-segment display.

---
 rtl/display_scan_controller.sv | 201 ++++++++++++++++++++
 tb/tb_display_scan_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
//-----------------------------------------------------------------------------
// display_scan_controller
//
// Time-multiplexed scan controller for a 4-digit seven-segment display.
// Sits directly upstream of the digit multiplexor and supplies the value,
// decimal points and digit select that the multiplexor decodes. It also drives
// the active-low anodes.
//
// Each digit slot is CLK_DIV cycles long. The anodes are held off for the
// first BLANK_CYCLES cycles of every slot so the previous digit's segment
// pattern cannot ghost onto the next digit. The displayed value and decimal
// points are captured once per frame, on the digit 3 -> 0 wrap (or when
// scanning starts), so a frame never mixes old and new data.
//
// Parameters
//   CLK_DIV       clock cycles per digit slot, blank interval included (>= 2)
//   BLANK_CYCLES  anodes-off cycles at the start of each slot
//                 (0 <= BLANK_CYCLES < CLK_DIV)
//
// Ports
//   clk           system clock
//   reset         asynchronous reset, active-high
//   enable        1 = scan the display; 0 = anodes off, scanning stopped
//   value_in      four nibbles, digit 3 in [15:12] ... digit 0 in [3:0]
//   dp_in         per-digit decimal points, active-low, bit n = digit n
//   value_out     frame-latched value for the multiplexor
//   dp_out        frame-latched decimal points for the multiplexor
//   digit_select  digit currently being scanned, 0..3
//   anode         active-low digit enables, registered
//   frame_tick    one-cycle pulse on every edge where value_out/dp_out load
//-----------------------------------------------------------------------------
module display_scan_controller #(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    output logic [15:0] value_out,
    output logic [3:0]  dp_out,
    output logic [1:0]  digit_select,
    output logic [3:0]  anode,
    output logic        frame_tick
);

    //-------------------------------------------------------------------------
    // Derived constants
    //-------------------------------------------------------------------------
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Last count value of a slot.
    localparam logic [CW-1:0] SLOT_LAST = CW'(CLK_DIV - 1);

    // Last count value of the blank interval. The BLANK state is never
    // entered when there is no blank interval, so the zero fallback is inert.
    localparam logic [CW-1:0] BLANK_LAST =
        (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : {CW{1'b0}};

    localparam bit NO_BLANK = (BLANK_CYCLES == 0);

    //-------------------------------------------------------------------------
    // Parameter legality check (elaboration time)
    //-------------------------------------------------------------------------
    if ((CLK_DIV < 2) || (BLANK_CYCLES < 0) || (BLANK_CYCLES >= CLK_DIV)) begin : g_param_check
        $error("display_scan_controller: need CLK_DIV >= 2 and 0 <= BLANK_CYCLES < CLK_DIV");
    end

    //-------------------------------------------------------------------------
    // State encoding
    //-------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    //-------------------------------------------------------------------------
    // Anode decode: only the scanned digit is driven low, and only while
    // showing. Used on next-state values so the anodes switch on the same
    // edge as state and digit_select.
    //-------------------------------------------------------------------------
    function automatic logic [3:0] anode_decode(input state_t st, input logic [1:0] dig);
        logic [3:0] a;
        a = 4'hF;
        if (st == ST_SHOW) begin
            a[dig] = 1'b0;
        end else begin
            a = 4'hF;
        end
        return a;
    endfunction

    //-------------------------------------------------------------------------
    // Registers and next-state signals
    //-------------------------------------------------------------------------
    state_t         state_q,  state_d;
    logic [CW-1:0]  cnt_q,    cnt_d;
    logic [1:0]     digit_q,  digit_d;
    logic [15:0]    value_q,  value_d;
    logic [3:0]     dp_q,     dp_d;
    logic [3:0]     anode_q,  anode_d;
    logic           tick_q,   tick_d;
    logic           latch_s;

    // Next-state logic: slot counting, digit advance, frame latch and anode decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        latch_s = 1'b0;

        if (!enable) begin
            // Disable wins over any slot-end or wrap event on this edge;
            // digit_select deliberately keeps its value.
            state_d = ST_OFF;
            cnt_d   = {CW{1'b0}};
        end else begin
            case (state_q)
                ST_OFF: begin
                    // Scanning starts at digit 0 with a fresh capture.
                    state_d = NO_BLANK ? ST_SHOW : ST_BLANK;
                    cnt_d   = {CW{1'b0}};
                    digit_d = 2'd0;
                    latch_s = 1'b1;
                end
                ST_BLANK: begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                    end else begin
                        state_d = ST_BLANK;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SLOT_LAST) begin
                        // End of slot: advance digit; 3 -> 0 is the frame wrap.
                        cnt_d   = {CW{1'b0}};
                        digit_d = digit_q + 2'd1;
                        state_d = NO_BLANK ? ST_SHOW : ST_BLANK;
                        if (digit_q == 2'd3) begin
                            latch_s = 1'b1;
                        end else begin
                            latch_s = 1'b0;
                        end
                    end else begin
                        cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                        state_d = ST_SHOW;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = {CW{1'b0}};
                end
            endcase
        end

        if (latch_s) begin
            value_d = value_in;
            dp_d    = dp_in;
        end else begin
            value_d = value_q;
            dp_d    = dp_q;
        end

        tick_d  = latch_s;
        anode_d = anode_decode(state_d, digit_d);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_OFF;
            cnt_q   <= {CW{1'b0}};
            digit_q <= 2'd0;
            value_q <= 16'h0000;
            dp_q    <= 4'hF;
            anode_q <= 4'hF;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            value_q <= value_d;
            dp_q    <= dp_d;
            anode_q <= anode_d;
            tick_q  <= tick_d;
        end
    end

    //-------------------------------------------------------------------------
    // Outputs (all straight from registers)
    //-------------------------------------------------------------------------
    assign value_out    = value_q;
    assign dp_out       = dp_q;
    assign digit_select = digit_q;
    assign anode        = anode_q;
    assign frame_tick   = tick_q;

endmodule

// File: tb/tb_display_scan_controller.sv
//-----------------------------------------------------------------------------
// Testbench for display_scan_controller.
// Two instances share the stimulus: dut_a (CLK_DIV=8, BLANK_CYCLES=2) and
// dut_b (CLK_DIV=8, BLANK_CYCLES=0). A behavioural model tracks elapsed
// scan time since enable and derives digit, blanking and latch events
// arithmetically from it.
//-----------------------------------------------------------------------------
module tb_display_scan_controller;

    localparam int CD      = 8;
    localparam int B_A     = 2;
    localparam int B_B     = 0;
    localparam int FRAME   = 4 * CD;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] value_in;
    logic [3:0]  dp_in;

    logic [15:0] a_value, b_value;
    logic [3:0]  a_dp,    b_dp;
    logic [1:0]  a_digit, b_digit;
    logic [3:0]  a_anode, b_anode;
    logic        a_tick,  b_tick;

    display_scan_controller #(.CLK_DIV(CD), .BLANK_CYCLES(B_A)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .value_in(value_in), .dp_in(dp_in),
        .value_out(a_value), .dp_out(a_dp), .digit_select(a_digit), .anode(a_anode),
        .frame_tick(a_tick)
    );

    display_scan_controller #(.CLK_DIV(CD), .BLANK_CYCLES(B_B)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .value_in(value_in), .dp_in(dp_in),
        .value_out(b_value), .dp_out(b_dp), .digit_select(b_digit), .anode(b_anode),
        .frame_tick(b_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // ---------------- behavioural model ----------------
    bit          m_on;
    int          m_t;      // cycles since scanning started, modulo one frame
    int          m_digit;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic        m_tick;

    task automatic model_reset();
        m_on = 1'b0; m_t = 0; m_digit = 0;
        m_val = 16'h0000; m_dp = 4'hF; m_tick = 1'b0;
    endtask

    task automatic model_edge();
        if (!enable) begin
            m_on = 1'b0; m_tick = 1'b0;
        end else if (!m_on) begin
            m_on = 1'b1; m_t = 0; m_digit = 0;
            m_val = value_in; m_dp = dp_in; m_tick = 1'b1;
        end else begin
            m_t     = (m_t + 1) % FRAME;
            m_digit = m_t / CD;
            m_tick  = (m_t == 0);
            if (m_tick) begin
                m_val = value_in; m_dp = dp_in;
            end
        end
    endtask

    function automatic logic [3:0] exp_anode(int blank);
        if (!m_on) return 4'hF;
        if ((m_t % CD) >= blank) return ~(4'b0001 << m_digit);
        return 4'hF;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_all();
        chk("a_value", a_value, m_val);
        chk("a_dp",    {12'd0, a_dp}, {12'd0, m_dp});
        chk("a_digit", {14'd0, a_digit}, 16'(m_digit));
        chk("a_anode", {12'd0, a_anode}, {12'd0, exp_anode(B_A)});
        chk("a_tick",  {15'd0, a_tick}, {15'd0, m_tick});
        chk("b_value", b_value, m_val);
        chk("b_dp",    {12'd0, b_dp}, {12'd0, m_dp});
        chk("b_digit", {14'd0, b_digit}, 16'(m_digit));
        chk("b_anode", {12'd0, b_anode}, {12'd0, exp_anode(B_B)});
        chk("b_tick",  {15'd0, b_tick}, {15'd0, m_tick});
    endtask

    // One clock edge: model follows the sampled inputs, outputs checked 1 ns later.
    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        cyc++;
        #1;
        check_all();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        en;
        logic [15:0] vin;
        logic [3:0]  dpin;
        logic [3:0]  e_anode;
        logic        e_tick;
        logic [1:0]  e_dig;
        logic [15:0] e_val;
        logic [3:0]  e_dp;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic [15:0] vin, logic [3:0] ea, logic et, logic [1:0] ed);
        vec_t v;
        v.en = 1'b1; v.vin = vin; v.dpin = 4'b1011;
        v.e_anode = ea; v.e_tick = et; v.e_dig = ed;
        v.e_val = 16'h1234; v.e_dp = 4'b1011;
        return v;
    endfunction

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int guard;
        int t0;

        // Scan start, blank, show digit 0, then digit 1; value changes mid digit 1.
        tbl[0]  = mk(16'h1234, 4'hF,    1'b1, 2'd0);
        tbl[1]  = mk(16'h1234, 4'hF,    1'b0, 2'd0);
        tbl[2]  = mk(16'h1234, 4'b1110, 1'b0, 2'd0);
        tbl[3]  = mk(16'h1234, 4'b1110, 1'b0, 2'd0);
        tbl[4]  = mk(16'h1234, 4'b1110, 1'b0, 2'd0);
        tbl[5]  = mk(16'h1234, 4'b1110, 1'b0, 2'd0);
        tbl[6]  = mk(16'h1234, 4'b1110, 1'b0, 2'd0);
        tbl[7]  = mk(16'h1234, 4'b1110, 1'b0, 2'd0);
        tbl[8]  = mk(16'h1234, 4'hF,    1'b0, 2'd1);
        tbl[9]  = mk(16'h1234, 4'hF,    1'b0, 2'd1);
        tbl[10] = mk(16'h1234, 4'b1101, 1'b0, 2'd1);
        tbl[11] = mk(16'h1234, 4'b1101, 1'b0, 2'd1);
        tbl[12] = mk(16'h5678, 4'b1101, 1'b0, 2'd1);
        tbl[13] = mk(16'h5678, 4'b1101, 1'b0, 2'd1);
        tbl[14] = mk(16'h5678, 4'b1101, 1'b0, 2'd1);
        tbl[15] = mk(16'h5678, 4'b1101, 1'b0, 2'd1);

        reset = 1'b1; enable = 1'b0; value_in = 16'hFFFF; dp_in = 4'h0;
        model_reset();
        #1;
        check_all();                       // reset state before any edge
        step(); step();
        reset = 1'b0;
        step(); step();                    // OFF with enable low

        for (int i = 0; i < 16; i++) begin
            enable = tbl[i].en; value_in = tbl[i].vin; dp_in = tbl[i].dpin;
            step();
            if (i == 0) t0 = cyc;
            chk("tbl_anode", {12'd0, a_anode}, {12'd0, tbl[i].e_anode});
            chk("tbl_tick",  {15'd0, a_tick},  {15'd0, tbl[i].e_tick});
            chk("tbl_digit", {14'd0, a_digit}, {14'd0, tbl[i].e_dig});
            chk("tbl_value", a_value, tbl[i].e_val);
            chk("tbl_dp",    {12'd0, a_dp},    {12'd0, tbl[i].e_dp});
        end

        // Value change takes effect only on the wrap edge, 32 cycles after start.
        guard = 0;
        while (!a_tick && guard < 40) begin step(); guard++; end
        chk("t2_tick_seen", {15'd0, a_tick}, 16'd1);
        chk("t2_period", 16'(cyc - t0), 16'(FRAME));
        chk("t2_value", a_value, 16'h5678);
        t0 = cyc;
        guard = 0;
        do begin step(); guard++; end while (!a_tick && guard < 40);
        chk("t2_period2", 16'(cyc - t0), 16'(FRAME));

        // Disable while digit 2 is showing.
        for (int i = 0; i < 20; i++) step();
        chk("t3_pre_anode", {12'd0, a_anode}, {12'd0, 4'b1011});
        enable = 1'b0;
        step();
        chk("t3_off_anode", {12'd0, a_anode}, {12'd0, 4'hF});
        chk("t3_off_tick",  {15'd0, a_tick},  16'd0);
        chk("t3_off_digit", {14'd0, a_digit}, 16'd2);
        step(); step();
        enable = 1'b1; value_in = 16'h9ABC; dp_in = 4'b0101;
        step();
        chk("t3_re_digit", {14'd0, a_digit}, 16'd0);
        chk("t3_re_value", a_value, 16'h9ABC);
        chk("t3_re_tick",  {15'd0, a_tick},  16'd1);
        chk("t3_re_blank0", {12'd0, a_anode}, {12'd0, 4'hF});
        step();
        chk("t3_re_blank1", {12'd0, a_anode}, {12'd0, 4'hF});
        step();
        chk("t3_re_show", {12'd0, a_anode}, {12'd0, 4'b1110});

        // Disable exactly on the wrap edge.
        guard = 0;
        while (!(m_on && m_t == FRAME - 1) && guard < 40) begin step(); guard++; end
        chk("t6_reached_wrap", {14'd0, a_digit}, 16'd3);
        enable = 1'b0; value_in = 16'hDEAD;
        step();
        chk("t6_tick",  {15'd0, a_tick}, 16'd0);
        chk("t6_value", a_value, 16'h9ABC);
        chk("t6_anode", {12'd0, a_anode}, {12'd0, 4'hF});
        chk("t6_digit", {14'd0, a_digit}, 16'd3);

        // Asynchronous reset in the middle of a SHOW slot.
        enable = 1'b1; value_in = 16'h1357;
        for (int i = 0; i < 11; i++) step();
        chk("t4_pre_anode", {12'd0, a_anode}, {12'd0, 4'b1101});
        reset = 1'b1;
        #2;
        model_reset();
        check_all();
        chk("t4_async_anode", {12'd0, a_anode}, {12'd0, 4'hF});
        chk("t4_async_value", a_value, 16'h0000);
        step(); step();
        enable = 1'b0; reset = 1'b0;
        step(); step(); step();
        chk("t4_off_anode", {12'd0, a_anode}, {12'd0, 4'hF});
        enable = 1'b1;
        step();
        chk("t4_start_tick", {15'd0, a_tick}, 16'd1);
        chk("t4_start_value", a_value, 16'h1357);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                check_all();
                step();
                reset = 1'b0;
            end
            enable   = ($urandom_range(0, 99) < 97);
            value_in = 16'($urandom);
            dp_in    = 4'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
